// File: rtl/ahb_lite_master_arbiter.sv
// Round-robin arbiter and AHB-Lite single-transfer master sequencer.
// One address slot (A) and one data slot (D) are pipelined; an ERROR cancels A and re-drives it.
module ahb_lite_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*3-1:0]          req_size,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         HADDR,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic [2:0]                    HSIZE,
  output logic [2:0]                    HBURST,
  output logic [3:0]                    HPROT,
  output logic [DATA_WIDTH-1:0]         HWDATA,
  input  logic [DATA_WIDTH-1:0]         HRDATA,
  input  logic                          HREADY,
  input  logic                          HRESP
);
  localparam int IDW = $clog2(NUM_REQ);
  typedef logic [IDW-1:0] id_t;
  typedef logic [IDW:0]   sum_t;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_BUSY = 2'b01, ST_ERR_CANCEL = 2'b10} state_t;

  state_t                state_q, state_d;
  id_t                   ptr_q, ptr_d;
  logic                  a_valid_q, a_valid_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic                  a_write_q, a_write_d;
  logic [2:0]            a_size_q, a_size_d;
  id_t                   a_owner_q, a_owner_d;
  logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
  logic                  d_valid_q, d_valid_d;
  id_t                   d_owner_q, d_owner_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic grant_found_s;
  id_t  grant_idx_s;
  logic first_err_s, advance_s, d_done_s, accept_s;

  function automatic logic [NUM_REQ-1:0] onehot(input id_t id);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id_t'(i) == id) v[i] = 1'b1;
      else v[i] = 1'b0;
    end
    return v;
  endfunction

  // Round-robin search starting at the priority pointer
  always_comb begin
    sum_t s;
    id_t  cand;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    s             = '0;
    cand          = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = sum_t'(ptr_q) + sum_t'(k);
      if (s >= sum_t'(NUM_REQ)) s = s - sum_t'(NUM_REQ);
      else s = s;
      cand = s[IDW-1:0];
      if (!grant_found_s && req_valid[cand]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Acceptance is blocked in both ERROR cycles and while A is stalled
  always_comb begin
    first_err_s = d_valid_q && !HREADY && HRESP && (state_q != ST_ERR_CANCEL);
    advance_s   = HREADY && (state_q != ST_ERR_CANCEL);
    d_done_s    = HREADY && d_valid_q;
    accept_s    = grant_found_s && (state_q != ST_ERR_CANCEL) && !first_err_s &&
                  (!a_valid_q || (HREADY && !HRESP));
    if (accept_s) req_ready = onehot(grant_idx_s);
    else req_ready = '0;
  end

  // Slot movement, completion and FSM next state
  always_comb begin
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_owner_d   = a_owner_q;
    a_wdata_d   = a_wdata_q;
    d_owner_d   = d_owner_q;
    hwdata_d    = hwdata_q;
    ptr_d       = ptr_q;
    rsp_rdata_d = rsp_rdata_q;
    state_d     = state_q;

    if (d_done_s) d_valid_d = 1'b0;
    else d_valid_d = d_valid_q;

    if (advance_s && a_valid_q) begin
      a_valid_d = 1'b0;
      d_valid_d = 1'b1;
      d_owner_d = a_owner_q;
      hwdata_d  = a_wdata_q;
    end else begin
      a_valid_d = a_valid_d;
    end

    if (accept_s) begin
      a_valid_d = 1'b1;
      a_addr_d  = req_addr[int'(grant_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
      a_write_d = req_write[grant_idx_s];
      a_size_d  = req_size[int'(grant_idx_s)*3 +: 3];
      a_wdata_d = req_wdata[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      a_owner_d = grant_idx_s;
      if (grant_idx_s == id_t'(NUM_REQ-1)) ptr_d = '0;
      else ptr_d = grant_idx_s + id_t'(1);
    end else begin
      ptr_d = ptr_q;
    end

    if (d_done_s) begin
      rsp_valid_d = onehot(d_owner_q);
      rsp_err_d   = HRESP;
      rsp_rdata_d = HRDATA;
    end else begin
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_BUSY: begin
        if (first_err_s) state_d = ST_ERR_CANCEL;
        else if (a_valid_d || d_valid_d) state_d = ST_BUSY;
        else state_d = ST_IDLE;
      end
      ST_ERR_CANCEL: begin
        if (!HREADY) state_d = ST_ERR_CANCEL;
        else if (a_valid_d || d_valid_d) state_d = ST_BUSY;
        else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight transfer silently
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      a_write_q   <= 1'b0;
      a_size_q    <= 3'b000;
      a_owner_q   <= '0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_owner_q   <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_owner_q   <= a_owner_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_owner_q   <= d_owner_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // A cancelled transfer stays in A but shows IDLE during the second ERROR cycle
  assign HTRANS    = (a_valid_q && (state_q != ST_ERR_CANCEL)) ? 2'b10 : 2'b00;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
